// File: rtl/channel_arbiter.sv
// channel_arbiter: several producers share one registered output channel.
// Each input owns a small FIFO that absorbs collisions. A round-robin
// scheduler moves one word per cycle from the FIFO heads into the output
// register, and each word is tagged with the index of the input that sent it.
module channel_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SRC_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_INPUTS*WIDTH-1:0]   in_data,
    input  logic [NUM_INPUTS-1:0]         in_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    output logic [SRC_WIDTH-1:0]          out_source,
    output logic [NUM_INPUTS-1:0]         overflow,
    input  logic                          clear_overflow,
    output logic                          busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // The count has one more bit than the pointers, so a full FIFO and an
    // empty FIFO can be told apart even though their pointers are equal.
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = SRC_WIDTH + 1;

    localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [RR_W-1:0]      N_EXT     = RR_W'(NUM_INPUTS);
    localparam logic [SRC_WIDTH-1:0] LAST_IDX  = SRC_WIDTH'(NUM_INPUTS - 1);

    logic [NUM_INPUTS-1:0] nonempty;
    logic [NUM_INPUTS-1:0] push;
    logic [NUM_INPUTS-1:0] pop;
    logic [NUM_INPUTS-1:0] drop;
    logic [WIDTH-1:0]      head_data [NUM_INPUTS];

    logic                  grant_valid;
    logic [SRC_WIDTH-1:0]  grant_idx;
    logic [SRC_WIDTH-1:0]  last_grant_reg;
    logic [RR_W-1:0]       rr_sum;
    logic [SRC_WIDTH-1:0]  rr_cand;

    // Per-input FIFOs
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_fifo
        logic [WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0] wr_ptr_reg;
        logic [PTR_W-1:0] rd_ptr_reg;
        logic [CNT_W-1:0] count_reg;
        logic             full;

        assign full          = (count_reg == DEPTH_CNT);
        assign nonempty[gi]  = (count_reg != '0);
        assign pop[gi]       = grant_valid && (grant_idx == SRC_WIDTH'(gi));
        // A full FIFO still accepts a word when its head leaves on the same
        // edge; the new word goes into the slot being freed.
        assign push[gi]      = in_valid[gi] && (!full || pop[gi]);
        assign drop[gi]      = in_valid[gi] && !push[gi];
        // The head is read combinationally so a word reaches the output
        // register one edge after it was written.
        assign head_data[gi] = mem[rd_ptr_reg];

        // Word storage: written on push, never reset
        always_ff @(posedge clk) begin
            if (push[gi]) begin
                mem[wr_ptr_reg] <= in_data[gi*WIDTH +: WIDTH];
            end
        end

        // Pointer and occupancy bookkeeping
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push[gi]) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                case ({push[gi], pop[gi]})
                    2'b10:   count_reg <= count_reg + CNT_W'(1);
                    2'b01:   count_reg <= count_reg - CNT_W'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // Round-robin pick: first non-empty FIFO after the last winner, wrapping
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_sum      = '0;
        rr_cand     = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            rr_sum = {1'b0, last_grant_reg} + RR_W'(k);
            if (rr_sum >= N_EXT) begin
                rr_sum = rr_sum - N_EXT;
            end
            rr_cand = rr_sum[SRC_WIDTH-1:0];
            if (!grant_valid && nonempty[rr_cand]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_cand;
            end
        end
    end

    // Output register and last-grant pointer; data and tag hold when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_source     <= '0;
            last_grant_reg <= LAST_IDX;
        end else begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data       <= head_data[grant_idx];
                out_source     <= grant_idx;
                last_grant_reg <= grant_idx;
            end
        end
    end

    // Sticky drop flags: a new drop on the clearing edge keeps its flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= '0;
        end else begin
            overflow <= (overflow & ~{NUM_INPUTS{clear_overflow}}) | drop;
        end
    end

    assign busy = |nonempty;

endmodule

// File: tb/tb_channel_arbiter.sv
// Testbench for channel_arbiter: directed scenarios plus random traffic.
// A queue-based reference model predicts every output word; a negedge
// monitor compares what the DUT emits against that prediction.
module tb_channel_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic           clear_overflow = 1'b0;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic [SW-1:0]  out_source;
    logic [N-1:0]   overflow;
    logic           busy;

    channel_arbiter #(
        .NUM_INPUTS (N),
        .WIDTH      (W),
        .FIFO_DEPTH (D),
        .SRC_WIDTH  (SW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_source     (out_source),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int           src;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] mq [N][$];
    int           last_grant = N - 1;
    bit [N-1:0]   m_ovf = '0;
    bit           m_valid = 1'b0;
    int           src_cnt [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model: one queue per input, round-robin over the non-empty
    // queues, then enqueue (space freed by this edge's pop is usable)
    always @(posedge clk or negedge reset) begin
        int   win;
        exp_t e;
        int   c;
        if (!reset) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            exp_q.delete();
            last_grant = N - 1;
            m_ovf      = '0;
            m_valid    = 1'b0;
        end else begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
                c = (last_grant + k) % N;
                if (win < 0 && mq[c].size() > 0) win = c;
            end
            m_valid = (win >= 0);
            if (win >= 0) begin
                e.src  = win;
                e.data = mq[win].pop_front();
                exp_q.push_back(e);
                last_grant = win;
            end
            if (clear_overflow) m_ovf = '0;
            for (int i = 0; i < N; i++) begin
                if (in_valid[i]) begin
                    if (mq[i].size() < D) mq[i].push_back(in_data[i*W +: W]);
                    else m_ovf[i] = 1'b1;
                end
            end
        end
    end

    // Monitor: compare DUT outputs with the model away from the rising edge
    always @(negedge clk) begin
        exp_t e;
        bit   mb;
        if (!reset) begin
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_overflow", 64'(overflow), 64'(0));
        end else begin
            check("out_valid", 64'(out_valid), 64'(m_valid));
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got src=%0d data=%0h expected no word", out_source, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_source", 64'(out_source), 64'(e.src));
                    check("out_data", 64'(out_data), 64'(e.data));
                    $display("word src=%0d data=%02h", out_source, out_data);
                end
                src_cnt[out_source]++;
            end
            mb = 1'b0;
            for (int i = 0; i < N; i++) if (mq[i].size() > 0) mb = 1'b1;
            check("busy", 64'(busy), 64'(mb));
            check("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    // Present inputs for one rising edge; returns at the following negedge
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d);
        in_valid = v;
        in_data  = d;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        in_valid = '0;
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held for 200ns, then idle
        #202 reset = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            cycle('0, '0);
            check("t1_out_valid", 64'(out_valid), 64'(0));
            check("t1_overflow", 64'(overflow), 64'(0));
            check("t1_busy", 64'(busy), 64'(0));
        end

        // 2: single word on input 2
        cycle(4'b0100, {8'h00, 8'hAA, 16'h0000});
        check("t2_early_valid", 64'(out_valid), 64'(0));
        check("t2_busy_k", 64'(busy), 64'(1));
        cycle('0, '0);
        check("t2_valid", 64'(out_valid), 64'(1));
        check("t2_data", 64'(out_data), 64'(8'hAA));
        check("t2_source", 64'(out_source), 64'(2));
        check("t2_busy_k1", 64'(busy), 64'(0));
        cycle('0, '0);
        check("t2_valid_off", 64'(out_valid), 64'(0));

        // 3: burst on all inputs, input 0 first after reset
        apply_reset();
        cycle(4'hF, {8'h13, 8'h12, 8'h11, 8'h10});
        for (int i = 0; i < N; i++) begin
            cycle('0, '0);
            check("t3_valid", 64'(out_valid), 64'(1));
            check("t3_source", 64'(out_source), 64'(i));
            check("t3_data", 64'(out_data), 64'(8'h10 + i));
        end
        cycle('0, '0);
        check("t3_valid_off", 64'(out_valid), 64'(0));

        // 4: inputs 0 and 1 backlogged. Seven cycles: the two share one
        // word per cycle, so an eighth would overrun input 1's FIFO.
        for (int n = 0; n < 16; n++) begin
            cycle((n < 7) ? 4'b0011 : 4'b0000, {16'h0000, 8'(8'h30 + n), 8'(8'h20 + n)});
            if (n >= 1 && n <= 14) begin
                check("t4_valid", 64'(out_valid), 64'(1));
                check("t4_source", 64'(out_source), 64'((n - 1) % 2));
                check("t4_data", 64'(out_data), 64'((((n - 1) % 2 == 0) ? 8'h20 : 8'h30) + (n - 1) / 2));
            end
            if (n == 15) check("t4_valid_off", 64'(out_valid), 64'(0));
        end
        check("t4_overflow", 64'(overflow), 64'(0));

        // 5: six edges of all-input traffic overruns inputs 1-3
        apply_reset();
        for (int i = 0; i < N; i++) src_cnt[i] = 0;
        for (int n = 0; n < 6; n++) begin
            cycle(4'hF, {4{8'(8'h40 + n)}});
        end
        check("t5_overflow_set", 64'(overflow), 64'(4'b1110));
        in_valid = '0;
        repeat (24) @(negedge clk);
        check("t5_cnt0", 64'(src_cnt[0]), 64'(6));
        check("t5_cnt1", 64'(src_cnt[1]), 64'(5));
        check("t5_cnt2", 64'(src_cnt[2]), 64'(5));
        check("t5_cnt3", 64'(src_cnt[3]), 64'(5));
        clear_overflow = 1'b1;
        cycle('0, '0);
        clear_overflow = 1'b0;
        check("t5_overflow_clr", 64'(overflow), 64'(0));

        // 6: asynchronous reset with every FIFO full
        apply_reset();
        for (int n = 0; n < 5; n++) begin
            cycle(4'hF, {4{8'(8'h50 + n)}});
        end
        in_valid = '0;
        #2;
        check("t6_busy_before", 64'(busy), 64'(1));
        check("t6_valid_before", 64'(out_valid), 64'(1));
        reset = 1'b0;
        #1;
        check("t6_valid_async", 64'(out_valid), 64'(0));
        check("t6_busy_async", 64'(busy), 64'(0));
        check("t6_overflow_async", 64'(overflow), 64'(0));
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            cycle('0, '0);
            check("t6_idle_valid", 64'(out_valid), 64'(0));
        end
        cycle(4'b1000, {8'h77, 24'h000000});
        check("t6_early_valid", 64'(out_valid), 64'(0));
        cycle('0, '0);
        check("t6_valid", 64'(out_valid), 64'(1));
        check("t6_source", 64'(out_source), 64'(3));
        check("t6_data", 64'(out_data), 64'(8'h77));

        // Random traffic: sparse first, then dense with occasional clears
        for (int n = 0; n < 400; n++) begin
            logic [N-1:0]   v;
            logic [N*W-1:0] d;
            v = (n < 200) ? N'($urandom & $urandom) : N'($urandom);
            d = (N*W)'($urandom);
            clear_overflow = ($urandom_range(0, 15) == 0);
            cycle(v, d);
        end
        clear_overflow = 1'b0;
        in_valid = '0;
        repeat (4 * D * N) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        check("drain_busy", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
